// File: rtl/usb_tx_packetizer.sv
`default_nettype none
// usb_tx_packetizer: buffers payload bytes and emits USB handshake/data packets
// as a header cycle followed by the payload, one byte per clock.

module usb_tx_packetizer #(
  parameter int MAX_PKT = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wr_valid,
  input  logic [7:0]  wr_data,
  output logic        wr_ready,
  input  logic        flush,
  input  logic        hs_req,
  input  logic [3:0]  hs_pid,
  input  logic        data_req,
  input  logic [3:0]  data_pid,
  output logic        busy,
  output logic        done,
  output logic        pid_err,
  output logic        host_tx_valid,
  output logic [3:0]  host_tx_pid,
  output logic [7:0]  host_tx_data,
  output logic [15:0] host_tx_len
);

  localparam int c_aw = $clog2(MAX_PKT);
  localparam int c_cw = $clog2(MAX_PKT + 1);
  localparam logic [c_cw-1:0] c_max = c_cw'(MAX_PKT);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_HDR     = 2'd1,
    S_PAYLOAD = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  state_t          r_state;
  logic [7:0]      r_buf [0:MAX_PKT-1];
  logic [c_cw-1:0] r_count;
  logic [c_cw-1:0] r_len;
  logic [c_cw-1:0] r_rd_ptr;
  logic            r_is_data;
  logic            r_wr_ready;
  logic            r_busy;
  logic            r_done;
  logic            r_pid_err;
  logic            r_tx_valid;
  logic [3:0]      r_tx_pid;
  logic [7:0]      r_tx_data;
  logic [15:0]     r_tx_len;

  logic            w_hs_ok;
  logic            w_data_ok;
  logic            w_wr_en;
  logic [c_cw-1:0] w_count_nxt;
  logic [c_cw-1:0] w_rd_nxt;
  logic [7:0]      w_rd_byte;

  assign w_hs_ok   = (hs_pid == 4'h2) || (hs_pid == 4'hA) ||
                     (hs_pid == 4'hE) || (hs_pid == 4'h6);
  assign w_data_ok = (data_pid == 4'h3) || (data_pid == 4'hB) ||
                     (data_pid == 4'h7) || (data_pid == 4'hF);

  // r_wr_ready mirrors (count < MAX_PKT) while idle, so it alone gates writes.
  assign w_wr_en     = (r_state == S_IDLE) && wr_valid && r_wr_ready && !flush;
  assign w_count_nxt = flush ? '0 : (w_wr_en ? r_count + c_cw'(1) : r_count);
  assign w_rd_nxt    = r_rd_ptr + c_cw'(1);
  assign w_rd_byte   = r_buf[w_rd_nxt[c_aw-1:0]];

  always_ff @(posedge clk) begin
    if (w_wr_en) r_buf[r_count[c_aw-1:0]] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_count    <= '0;
      r_len      <= '0;
      r_rd_ptr   <= '0;
      r_is_data  <= 1'b0;
      r_wr_ready <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_pid_err  <= 1'b0;
      r_tx_valid <= 1'b0;
      r_tx_pid   <= '0;
      r_tx_data  <= '0;
      r_tx_len   <= '0;
    end else begin
      r_done    <= 1'b0;
      r_pid_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_count    <= w_count_nxt;
          r_wr_ready <= (w_count_nxt < c_max);
          if (hs_req) begin
            if (w_hs_ok) begin
              r_state    <= S_HDR;
              r_is_data  <= 1'b0;
              r_len      <= '0;
              r_wr_ready <= 1'b0;
              r_busy     <= 1'b1;
              r_tx_valid <= 1'b1;
              r_tx_pid   <= hs_pid;
              r_tx_len   <= '0;
              r_tx_data  <= 8'h00;
            end else begin
              r_pid_err <= 1'b1;
            end
          end else if (data_req) begin
            if (w_data_ok) begin
              // A byte accepted in the request cycle is part of the packet.
              r_state    <= S_HDR;
              r_is_data  <= 1'b1;
              r_len      <= w_count_nxt;
              r_wr_ready <= 1'b0;
              r_busy     <= 1'b1;
              r_tx_valid <= 1'b1;
              r_tx_pid   <= data_pid;
              r_tx_len   <= 16'(w_count_nxt);
              r_tx_data  <= 8'h00;
            end else begin
              r_pid_err <= 1'b1;
            end
          end
        end
        S_HDR: begin
          if (r_len == '0) begin
            r_state    <= S_DONE;
            r_done     <= 1'b1;
            r_tx_valid <= 1'b0;
            r_tx_pid   <= '0;
            r_tx_len   <= '0;
            r_tx_data  <= '0;
          end else begin
            r_state   <= S_PAYLOAD;
            r_rd_ptr  <= '0;
            r_tx_data <= r_buf[0];
          end
        end
        S_PAYLOAD: begin
          if (w_rd_nxt == r_len) begin
            r_state    <= S_DONE;
            r_done     <= 1'b1;
            r_tx_valid <= 1'b0;
            r_tx_pid   <= '0;
            r_tx_len   <= '0;
            r_tx_data  <= '0;
          end else begin
            r_rd_ptr  <= w_rd_nxt;
            r_tx_data <= w_rd_byte;
          end
        end
        S_DONE: begin
          r_state  <= S_IDLE;
          r_busy   <= 1'b0;
          r_rd_ptr <= '0;
          if (r_is_data) begin
            r_count    <= '0;
            r_wr_ready <= 1'b1;
          end else begin
            r_wr_ready <= (r_count < c_max);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign wr_ready      = r_wr_ready;
  assign busy          = r_busy;
  assign done          = r_done;
  assign pid_err       = r_pid_err;
  assign host_tx_valid = r_tx_valid;
  assign host_tx_pid   = r_tx_pid;
  assign host_tx_data  = r_tx_data;
  assign host_tx_len   = r_tx_len;

endmodule

`default_nettype wire

// File: tb/tb_usb_tx_packetizer.sv
`default_nettype none
// Directed self-checking bench for usb_tx_packetizer (MAX_PKT = 16).

module tb_usb_tx_packetizer;

  localparam int MAX_PKT = 16;

  logic        clk;
  logic        rst_n;
  logic        wr_valid;
  logic [7:0]  wr_data;
  logic        wr_ready;
  logic        flush;
  logic        hs_req;
  logic [3:0]  hs_pid;
  logic        data_req;
  logic [3:0]  data_pid;
  logic        busy;
  logic        done;
  logic        pid_err;
  logic        host_tx_valid;
  logic [3:0]  host_tx_pid;
  logic [7:0]  host_tx_data;
  logic [15:0] host_tx_len;

  int          n_checks;
  int          n_errors;
  logic [7:0]  exp_q[$];

  usb_tx_packetizer #(.MAX_PKT(MAX_PKT)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .wr_valid     (wr_valid),
    .wr_data      (wr_data),
    .wr_ready     (wr_ready),
    .flush        (flush),
    .hs_req       (hs_req),
    .hs_pid       (hs_pid),
    .data_req     (data_req),
    .data_pid     (data_pid),
    .busy         (busy),
    .done         (done),
    .pid_err      (pid_err),
    .host_tx_valid(host_tx_valid),
    .host_tx_pid  (host_tx_pid),
    .host_tx_data (host_tx_data),
    .host_tx_len  (host_tx_len)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic [7:0] d);
    wr_valid = 1'b1;
    wr_data  = d;
    tick();
    wr_valid = 1'b0;
  endtask

  task automatic req_data(input logic [3:0] pid);
    data_req = 1'b1;
    data_pid = pid;
    tick();
    data_req = 1'b0;
  endtask

  task automatic req_hs(input logic [3:0] pid);
    hs_req = 1'b1;
    hs_pid = pid;
    tick();
    hs_req = 1'b0;
  endtask

  // Entered with the header cycle visible; walks payload (from exp_q), DONE and back to IDLE.
  task automatic run_packet(input string tag, input logic [3:0] pid, input int len);
    check({tag, "_hdr_valid"}, 32'(host_tx_valid), 32'd1);
    check({tag, "_hdr_pid"}, 32'(host_tx_pid), 32'(pid));
    check({tag, "_hdr_len"}, 32'(host_tx_len), 32'(len));
    check({tag, "_hdr_data"}, 32'(host_tx_data), 32'h0);
    check({tag, "_hdr_busy"}, 32'(busy), 32'd1);
    for (int i = 0; i < len; i++) begin
      tick();
      check($sformatf("%s_byte%0d", tag, i), 32'(host_tx_data), 32'(exp_q[i]));
      check($sformatf("%s_valid%0d", tag, i), 32'(host_tx_valid), 32'd1);
      check($sformatf("%s_pid%0d", tag, i), 32'(host_tx_pid), 32'(pid));
      check($sformatf("%s_len%0d", tag, i), 32'(host_tx_len), 32'(len));
    end
    tick();
    check({tag, "_done_valid"}, 32'(host_tx_valid), 32'd0);
    check({tag, "_done_pulse"}, 32'(done), 32'd1);
    check({tag, "_done_busy"}, 32'(busy), 32'd1);
    tick();
    check({tag, "_idle_done"}, 32'(done), 32'd0);
    check({tag, "_idle_busy"}, 32'(busy), 32'd0);
    check({tag, "_idle_valid"}, 32'(host_tx_valid), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n    = 1'b0;
    wr_valid = 1'b0;
    wr_data  = 8'h00;
    flush    = 1'b0;
    hs_req   = 1'b0;
    hs_pid   = 4'h0;
    data_req = 1'b0;
    data_pid = 4'h0;
    tick();
    tick();
    check("rst_wr_ready", 32'(wr_ready), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_pid_err", 32'(pid_err), 32'd0);
    check("rst_valid", 32'(host_tx_valid), 32'd0);
    check("rst_pid", 32'(host_tx_pid), 32'd0);
    check("rst_data", 32'(host_tx_data), 32'd0);
    check("rst_len", 32'(host_tx_len), 32'd0);
    rst_n = 1'b1;
    tick();
    check("post_rst_wr_ready", 32'(wr_ready), 32'd1);

    // Basic three-byte DATA0 packet, then a zero-length one proving count was cleared.
    put(8'h11); put(8'h22); put(8'h33);
    exp_q = '{8'h11, 8'h22, 8'h33};
    req_data(4'h3);
    run_packet("d0", 4'h3, 3);
    exp_q.delete();
    req_data(4'h3);
    run_packet("d0_empty", 4'h3, 0);

    // ACK with two bytes buffered leaves the buffer for the next data packet.
    put(8'hAA); put(8'hBB);
    req_hs(4'h2);
    run_packet("ack", 4'h2, 0);
    exp_q = '{8'hAA, 8'hBB};
    req_data(4'hB);
    run_packet("ack_buf", 4'hB, 2);

    // Overfill: wr_ready drops after MAX_PKT accepted bytes, extras are discarded.
    exp_q.delete();
    for (int i = 0; i < MAX_PKT + 5; i++) begin
      check($sformatf("full_wr_ready%0d", i), 32'(wr_ready), (i < MAX_PKT) ? 32'd1 : 32'd0);
      wr_valid = 1'b1;
      wr_data  = 8'(i * 7 + 3);
      if (i < MAX_PKT) exp_q.push_back(8'(i * 7 + 3));
      tick();
    end
    wr_valid = 1'b0;
    req_data(4'hB);
    run_packet("full", 4'hB, MAX_PKT);
    check("full_wr_ready_after", 32'(wr_ready), 32'd1);

    // Bad PIDs.
    req_hs(4'h1);
    check("bad_hs_err", 32'(pid_err), 32'd1);
    check("bad_hs_valid", 32'(host_tx_valid), 32'd0);
    check("bad_hs_busy", 32'(busy), 32'd0);
    tick();
    check("bad_hs_err_clr", 32'(pid_err), 32'd0);
    check("bad_hs_valid2", 32'(host_tx_valid), 32'd0);
    req_data(4'h2);
    check("bad_data_err", 32'(pid_err), 32'd1);
    check("bad_data_valid", 32'(host_tx_valid), 32'd0);
    tick();
    check("bad_data_err_clr", 32'(pid_err), 32'd0);
    check("bad_data_valid2", 32'(host_tx_valid), 32'd0);

    // Simultaneous requests: NAK wins, data_req dropped; requests during PAYLOAD ignored.
    put(8'h5A); put(8'hA5);
    hs_req = 1'b1; hs_pid = 4'hA; data_req = 1'b1; data_pid = 4'h3;
    tick();
    hs_req = 1'b0; data_req = 1'b0;
    exp_q.delete();
    check("both_err", 32'(pid_err), 32'd0);
    run_packet("both_nak", 4'hA, 0);
    req_data(4'h3);
    check("pl_hdr_pid", 32'(host_tx_pid), 32'h3);
    check("pl_hdr_len", 32'(host_tx_len), 32'd2);
    tick();
    check("pl_b0", 32'(host_tx_data), 32'h5A);
    hs_req = 1'b1; hs_pid = 4'h2; data_req = 1'b1; data_pid = 4'hB; flush = 1'b1;
    tick();
    hs_req = 1'b0; data_req = 1'b0; flush = 1'b0;
    check("pl_b1", 32'(host_tx_data), 32'hA5);
    check("pl_b1_pid", 32'(host_tx_pid), 32'h3);
    check("pl_b1_len", 32'(host_tx_len), 32'd2);
    check("pl_b1_err", 32'(pid_err), 32'd0);
    tick();
    check("pl_done", 32'(done), 32'd1);
    check("pl_done_valid", 32'(host_tx_valid), 32'd0);
    tick();
    check("pl_idle_valid", 32'(host_tx_valid), 32'd0);

    // Flush wins over a same-cycle write.
    put(8'h01); put(8'h02); put(8'h03);
    wr_valid = 1'b1; wr_data = 8'h04; flush = 1'b1;
    tick();
    wr_valid = 1'b0; flush = 1'b0;
    req_data(4'hF);
    run_packet("flush", 4'hF, 0);

    // Reset in the middle of PAYLOAD aborts immediately, with no done pulse.
    put(8'hC1); put(8'hC2); put(8'hC3); put(8'hC4);
    req_data(4'h7);
    check("abort_hdr_len", 32'(host_tx_len), 32'd4);
    tick();
    check("abort_b0", 32'(host_tx_data), 32'hC1);
    tick();
    check("abort_b1", 32'(host_tx_data), 32'hC2);
    rst_n = 1'b0;
    #1;
    check("abort_valid", 32'(host_tx_valid), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_data", 32'(host_tx_data), 32'd0);
    check("abort_wr_ready", 32'(wr_ready), 32'd0);
    tick();
    check("abort_done2", 32'(done), 32'd0);
    rst_n = 1'b1;
    tick();
    check("abort_rel_wr_ready", 32'(wr_ready), 32'd1);
    check("abort_rel_done", 32'(done), 32'd0);
    check("abort_rel_valid", 32'(host_tx_valid), 32'd0);
    exp_q.delete();
    req_data(4'h3);
    run_packet("zero_len", 4'h3, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/usb_tx_packetizer.md
USB_TX_PACKETIZER -- requirements
Module: usb_tx_packetizer

Interface
REQ-001 SHALL have parameter MAX_PKT, default 64: payload buffer depth in bytes (power of 2, 8..512).
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port wr_valid, input, 1 bit: payload byte offered.
REQ-005 SHALL have port wr_data, input, 8 bits: payload byte.
REQ-006 SHALL have port wr_ready, output, 1 bit: byte accepted when wr_valid && wr_ready.
REQ-007 SHALL have port flush, input, 1 bit: discard buffered payload.
REQ-008 SHALL have port hs_req, input, 1 bit: send a handshake packet.
REQ-009 SHALL have port hs_pid, input, 4 bits: handshake PID.
REQ-010 SHALL have port data_req, input, 1 bit: send a data packet from the buffer.
REQ-011 SHALL have port data_pid, input, 4 bits: data PID.
REQ-012 SHALL have port busy, output, 1 bit: packet in progress.
REQ-013 SHALL have port done, output, 1 bit: one-cycle pulse at end of packet.
REQ-014 SHALL have port pid_err, output, 1 bit: one-cycle pulse when a request is rejected for a bad PID.
REQ-015 SHALL have port host_tx_valid, output, 1 bit: packet cycle active.
REQ-016 SHALL have port host_tx_pid, output, 4 bits: PID of the current packet.
REQ-017 SHALL have port host_tx_data, output, 8 bits: payload byte.
REQ-018 SHALL have port host_tx_len, output, 16 bits: payload length of the current packet.

Function
REQ-019 SHALL implement states IDLE, HDR, PAYLOAD, DONE.
REQ-020 SHALL, in IDLE only, assert wr_ready = (count < MAX_PKT); each accepted byte is stored at buf[count] and count increments; wr_ready SHALL be 0 in all other states.
REQ-021 SHALL ignore wr_valid when count == MAX_PKT: no write, no count change, no wrap.
REQ-022 SHALL, on flush in IDLE, set count to 0; flush has priority over a same-cycle write; flush SHALL be ignored outside IDLE.
REQ-023 SHALL accept handshake PIDs ACK 4'h2, NAK 4'hA, STALL 4'hE, NYET 4'h6 only.
REQ-024 SHALL accept data PIDs DATA0 4'h3, DATA1 4'hB, DATA2 4'h7, MDATA 4'hF only.
REQ-025 SHALL, on hs_req in IDLE with a valid PID: latch the PID, set len 0, go to HDR; the buffer is unchanged.
REQ-026 SHALL, on data_req in IDLE with a valid PID: latch the PID, set len = count, go to HDR.
REQ-027 SHALL give hs_req priority when hs_req and data_req are both asserted; data_req is then dropped without error.
REQ-028 SHALL, for a request with an invalid PID: stay in IDLE and pulse pid_err for 1 cycle.
REQ-029 SHALL ignore hs_req and data_req outside IDLE, with no pid_err.
REQ-030 SHALL, in HDR (exactly 1 cycle): drive host_tx_valid=1, host_tx_pid=latched PID, host_tx_len=len, host_tx_data=8'h00.
REQ-031 SHALL go from HDR to DONE if len == 0, else to PAYLOAD with rd_ptr = 0.
REQ-032 SHALL, in PAYLOAD: drive host_tx_valid=1 and host_tx_data=buf[rd_ptr] for exactly len cycles, rd_ptr incrementing each cycle; host_tx_pid and host_tx_len SHALL be held constant.
REQ-033 SHALL enter DONE after the last PAYLOAD byte.
REQ-034 SHALL, in DONE (1 cycle): host_tx_valid=0, done=1, count cleared to 0 only for data packets, next state IDLE.
REQ-035 SHALL set busy=1 in HDR, PAYLOAD and DONE.
REQ-036 SHALL make a packet occupy len+1 host_tx_valid cycles, contiguous with no gaps; the earliest next request is accepted in the cycle after DONE.
REQ-037 SHALL register all outputs; in IDLE, host_tx_valid=0 and host_tx_data/pid/len=0.
REQ-038 SHALL size len and count to cover MAX_PKT; host_tx_len SHALL be zero-extended to 16 bits.

Reset
REQ-039 SHALL, while rst_n=0, asynchronously force: state IDLE, count 0, rd_ptr 0, busy 0, done 0, pid_err 0, host_tx_valid 0, host_tx_pid 0, host_tx_data 0, host_tx_len 0, wr_ready 0 (1 from the first clock after release).
REQ-040 SHALL, on reset during HDR or PAYLOAD, abort the packet immediately with no done pulse; buffered payload is lost.
REQ-041 SHALL NOT require buffer storage contents to be reset.

Verification
REQ-042 SHALL check: write 3 bytes 11,22,33, then data_req with DATA0 -> 1 HDR cycle (pid 3, len 3, data 00), then bytes 11,22,33 on consecutive cycles, then done, count 0.
REQ-043 SHALL check: hs_req with ACK with 2 bytes buffered -> single valid cycle (pid 2, len 0), done next cycle, buffer still 2 bytes.
REQ-044 SHALL check: write MAX_PKT+5 bytes -> wr_ready drops after MAX_PKT; data_req with DATA1 -> len MAX_PKT, bytes intact.
REQ-045 SHALL check: hs_req with PID 4'h1, and separately data_req with PID 4'h2 -> pid_err pulse, no host_tx_valid.
REQ-046 SHALL check: hs_req NAK and data_req DATA0 in the same cycle -> NAK packet only; data_req during PAYLOAD -> ignored.
REQ-047 SHALL check: rst_n low mid-PAYLOAD -> host_tx_valid 0 immediately, no done; zero-length data_req -> HDR only, len 0.
